pong_match_ctrl: RTL

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/pause/game-over flow, scores, match clock and result.
// All outputs are registered; transitions land on the clk edge after the triggering input.
module pong_match_ctrl #(
  parameter int WIN_SCORE     = 5,
  parameter int SERVE_FRAMES  = 60,
  parameter int PAUSE_FRAMES  = 90,
  parameter int TICKS_PER_SEC = 60,
  parameter int MATCH_SECONDS = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start_btn,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       ball_enable,
  output logic       ball_recenter,
  output logic       serve_left,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [5:0] seconds_left,
  output logic [2:0] state,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > PAUSE_FRAMES) ? SERVE_FRAMES : PAUSE_FRAMES;
  localparam int FW = $clog2(MAX_FRAMES + 1);
  localparam int PW = $clog2(TICKS_PER_SEC + 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SERVE_WAIT  = 3'd1,
    PLAY        = 3'd2,
    POINT_PAUSE = 3'd3,
    GAME_OVER   = 3'd4
  } state_t;

  state_t        st;
  logic [FW-1:0] frame_cnt;
  logic [PW-1:0] presc;

  logic       p1_only, p2_only, presc_wrap, time_up, win;
  logic [3:0] nxt_p1, nxt_p2;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'd15) ? 4'd15 : s + 4'd1;
  endfunction

  function automatic logic [1:0] result(input logic [3:0] a, input logic [3:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  assign state = st;

  // Point and clock-expiry decisions for the PLAY state, evaluated in the same cycle.
  always_comb begin
    p1_only    = p1_point && !p2_point;
    p2_only    = p2_point && !p1_point;
    presc_wrap = refresh_tick && (presc == PW'(TICKS_PER_SEC - 1));
    time_up    = presc_wrap && (seconds_left == 6'd1);
    nxt_p1     = p1_only ? sat_inc(score_p1) : score_p1;
    nxt_p2     = p2_only ? sat_inc(score_p2) : score_p2;
    win        = (p1_only && (nxt_p1 == 4'(WIN_SCORE))) ||
                 (p2_only && (nxt_p2 == 4'(WIN_SCORE)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st            <= IDLE;
      frame_cnt     <= '0;
      presc         <= '0;
      ball_enable   <= 1'b0;
      ball_recenter <= 1'b0;
      serve_left    <= 1'b1;
      score_p1      <= 4'd0;
      score_p2      <= 4'd0;
      seconds_left  <= 6'(MATCH_SECONDS);
      game_over     <= 1'b0;
      winner        <= 2'b00;
    end else begin
      ball_recenter <= 1'b0;
      case (st)
        IDLE: begin
          frame_cnt    <= '0;
          presc        <= '0;
          ball_enable  <= 1'b0;
          score_p1     <= 4'd0;
          score_p2     <= 4'd0;
          seconds_left <= 6'(MATCH_SECONDS);
          game_over    <= 1'b0;
          winner       <= 2'b00;
          if (start_btn) begin
            st            <= SERVE_WAIT;
            ball_recenter <= 1'b1;
          end
        end
        SERVE_WAIT: begin
          if (refresh_tick) begin
            if (frame_cnt == FW'(SERVE_FRAMES - 1)) begin
              st          <= PLAY;
              frame_cnt   <= '0;
              ball_enable <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        PLAY: begin
          if (refresh_tick) begin
            if (presc_wrap) begin
              presc        <= '0;
              seconds_left <= seconds_left - 6'd1;
            end else begin
              presc <= presc + 1'b1;
            end
          end
          score_p1 <= nxt_p1;
          score_p2 <= nxt_p2;
          if (p1_only) serve_left <= 1'b0;
          if (p2_only) serve_left <= 1'b1;
          // A point landing on the final second is scored before the match closes.
          if (win || time_up) begin
            st          <= GAME_OVER;
            frame_cnt   <= '0;
            ball_enable <= 1'b0;
            game_over   <= 1'b1;
            winner      <= result(nxt_p1, nxt_p2);
          end else if (p1_point || p2_point) begin
            st          <= POINT_PAUSE;
            frame_cnt   <= '0;
            ball_enable <= 1'b0;
          end
        end
        POINT_PAUSE: begin
          if (refresh_tick) begin
            if (frame_cnt == FW'(PAUSE_FRAMES - 1)) begin
              st            <= SERVE_WAIT;
              frame_cnt     <= '0;
              ball_recenter <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (start_btn) begin
            st           <= IDLE;
            frame_cnt    <= '0;
            score_p1     <= 4'd0;
            score_p2     <= 4'd0;
            seconds_left <= 6'(MATCH_SECONDS);
            game_over    <= 1'b0;
            winner       <= 2'b00;
          end
        end
        default: begin
          st          <= IDLE;
          frame_cnt   <= '0;
          ball_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
